// File: rtl/dac_sweep_gen.sv
// dac_sweep_gen: multi-channel DAC sweep generator (sawtooth / triangle).
// One state machine (IDLE -> LOAD -> RUN) paces every channel; each
// channel steps independently between the shared limits lo and hi.
// Channel 0 alone defines the sweep period and the done pulse.
//
// Optional build macro: DAC_SWEEP_OFFSET_BINARY_EN
//   defined   -> dac_data presents each sample in offset binary (MSB inverted)
//   undefined -> dac_data presents the two's-complement sample unchanged
//
// Handshake: start and stop are single-cycle requests sampled on the rising
// clock edge. There is no back-pressure. data_valid is a one-cycle
// qualifier for dac_data, and done/err are one-cycle event pulses.
//
// Timing: the edge that accepts start loads lo into every channel, so
// dac_data = lo with data_valid high in the following (LOAD) cycle. The
// dwell counter runs from that same edge, so every sample, the first one
// included, is held for dwell+1 cycles.
module dac_sweep_gen #(
  parameter int WIDTH   = 16,
  parameter int NCH     = 2,
  parameter int DWELL_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  input  logic                    continuous,
  input  logic signed [WIDTH-1:0] lo,
  input  logic signed [WIDTH-1:0] hi,
  input  logic [NCH*WIDTH-1:0]    step,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [NCH*WIDTH-1:0]    dac_data,
  output logic                    data_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  // Two guard bits keep value+step and value-step free of overflow.
  localparam int AW = WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Configuration captured when a sweep is accepted.
  logic                    mode_q;
  logic                    cont_q;
  logic signed [WIDTH-1:0] lo_q;
  logic signed [WIDTH-1:0] hi_q;
  logic [NCH*WIDTH-1:0]    step_q;
  logic [DWELL_W-1:0]      dwell_q;

  // Sweep state: dwell counter, per-channel sample and direction (1 = down).
  logic [DWELL_W-1:0]      cnt_q;
  logic signed [WIDTH-1:0] samp_q [NCH];
  logic [NCH-1:0]          dir_q;
  logic                    valid_q;
  logic                    done_q;
  logic                    err_q;

  // Combinational helpers.
  logic                    start_ok;
  logic                    start_bad;
  logic                    tick;
  logic                    done_evt;
  logic signed [WIDTH-1:0] nxt_samp [NCH];
  logic [NCH-1:0]          nxt_dir;

  // Request decode: stop always wins over start.
  always_comb begin
    start_ok  = start && !stop && (lo < hi);
    start_bad = start && !stop && !(lo < hi);
    tick      = (state_q != S_IDLE) && (cnt_q == dwell_q);
  end

  // Next sample and direction for every channel, plus channel 0's end-of-period.
  always_comb begin
    logic signed [AW-1:0] cur;
    logic signed [AW-1:0] stp;
    logic signed [AW-1:0] lo_x;
    logic signed [AW-1:0] hi_x;
    logic signed [AW-1:0] up_sum;
    logic signed [AW-1:0] dn_sum;
    logic signed [AW-1:0] up_val;
    logic signed [AW-1:0] dn_val;
    lo_x     = {{2{lo_q[WIDTH-1]}}, lo_q};
    hi_x     = {{2{hi_q[WIDTH-1]}}, hi_q};
    done_evt = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cur    = {{2{samp_q[k][WIDTH-1]}}, samp_q[k]};
      stp    = {2'b00, step_q[k*WIDTH +: WIDTH]};
      up_sum = cur + stp;
      dn_sum = cur - stp;
      up_val = (up_sum > hi_x) ? hi_x : up_sum;
      dn_val = (dn_sum < lo_x) ? lo_x : dn_sum;
      nxt_dir[k]  = dir_q[k];
      nxt_samp[k] = samp_q[k];
      if (!mode_q) begin
        // Sawtooth: climb with clamp at hi, then jump back to lo.
        nxt_dir[k]  = 1'b0;
        nxt_samp[k] = (cur == hi_x) ? lo_q : up_val[WIDTH-1:0];
      end else if (!dir_q[k]) begin
        // Triangle rising: turn around once hi has been reached.
        if (cur == hi_x) begin
          nxt_dir[k]  = 1'b1;
          nxt_samp[k] = dn_val[WIDTH-1:0];
        end else begin
          nxt_samp[k] = up_val[WIDTH-1:0];
        end
      end else begin
        // Triangle falling: turn around once lo has been reached.
        if (cur == lo_x) begin
          nxt_dir[k]  = 1'b0;
          nxt_samp[k] = up_val[WIDTH-1:0];
        end else begin
          nxt_samp[k] = dn_val[WIDTH-1:0];
        end
      end
    end
    if (!mode_q) begin
      done_evt = (samp_q[0] == hi_q);
    end else begin
      done_evt = nxt_dir[0] && (nxt_samp[0] == lo_q);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_LOAD;
      end
      S_LOAD, S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick && done_evt && !cont_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and output formatting of the sample registers.
  always_comb begin
    busy       = (state_q != S_IDLE);
    dbg_state  = state_q;
    data_valid = valid_q;
    done       = done_q;
    err        = err_q;
    dac_data   = '0;
    for (int k = 0; k < NCH; k++) begin
`ifdef DAC_SWEEP_OFFSET_BINARY_EN
      dac_data[k*WIDTH +: WIDTH] = {~samp_q[k][WIDTH-1], samp_q[k][WIDTH-2:0]};
`else
      dac_data[k*WIDTH +: WIDTH] = samp_q[k];
`endif
    end
  end

  // Datapath: config capture, dwell counting, sample updates and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= 1'b0;
      cont_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) samp_q[k] <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start_ok) begin
          mode_q  <= mode;
          cont_q  <= continuous;
          lo_q    <= lo;
          hi_q    <= hi;
          step_q  <= step;
          dwell_q <= dwell;
          cnt_q   <= '0;
          dir_q   <= '0;
          valid_q <= 1'b1;
          for (int k = 0; k < NCH; k++) samp_q[k] <= lo;
        end else if (start_bad) begin
          err_q <= 1'b1;
        end
      end else if (!stop) begin
        if (tick) begin
          cnt_q   <= '0;
          dir_q   <= nxt_dir;
          valid_q <= 1'b1;
          done_q  <= done_evt;
          for (int k = 0; k < NCH; k++) samp_q[k] <= nxt_samp[k];
        end else begin
          cnt_q <= cnt_q + DWELL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_sweep_gen.sv
// tb_dac_sweep_gen: randomized bench for dac_sweep_gen. Expected samples come
// from closed-form sweep arithmetic (position inside the sweep period) and are
// queued per update; the DUT's data_valid pops the queue for comparison.
module tb_dac_sweep_gen;
  localparam int WIDTH   = 16;
  localparam int NCH     = 2;
  localparam int DWELL_W = 16;
  localparam int DW      = NCH * WIDTH;
  localparam int EW      = DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                 start, stop, mode, continuous;
  logic [WIDTH-1:0]     lo, hi;
  logic [DW-1:0]        step;
  logic [DWELL_W-1:0]   dwell;
  logic [DW-1:0]        dac_data;
  logic                 data_valid, busy, done, err;
  logic [1:0]           dbg_state;

  dac_sweep_gen #(.WIDTH(WIDTH), .NCH(NCH), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .continuous(continuous), .lo(lo), .hi(hi), .step(step), .dwell(dwell),
    .dac_data(dac_data), .data_valid(data_valid), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] held;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] out_map(input int v);
    logic [WIDTH-1:0] r;
    r = v[WIDTH-1:0];
`ifdef DAC_SWEEP_OFFSET_BINARY_EN
    r[WIDTH-1] = ~r[WIDTH-1];
`endif
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Number of updates in one full sweep of a channel (0 when it never moves).
  function automatic int period(input bit m, input int l, input int h, input int s);
    int j;
    if (s == 0) return 0;
    j = ceil_div(h - l, s);
    return m ? 2 * j : j + 1;
  endfunction

  // Sample value at update index idx, from its position within the sweep.
  function automatic int sample_at(input bit m, input int l, input int h, input int s, input int idx);
    int j, p, v;
    if (s == 0) return l;
    j = ceil_div(h - l, s);
    p = idx % period(m, l, h, s);
    if (p <= j) begin
      v = l + p * s;
      if (v > h) v = h;
    end else begin
      v = h - (p - j) * s;
      if (v < l) v = l;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] reset_word();
    logic [DW-1:0] w;
    for (int k = 0; k < NCH; k++) w[k*WIDTH +: WIDTH] = out_map(0);
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; mode = 1'b0; continuous = 1'b0;
    lo = '0; hi = '0; step = '0; dwell = '0;
  endtask

  task automatic scramble_inputs();
    mode       = 1'($urandom);
    continuous = 1'($urandom);
    lo         = WIDTH'($urandom);
    hi         = WIDTH'($urandom);
    step       = DW'($urandom);
    dwell      = DWELL_W'($urandom);
  endtask

  // Launch one sweep (called at a falling edge) and check every cycle until
  // the sweep has ended. stop_at = 0 means no stop; otherwise stop (together
  // with a start) is raised during cycle stop_at after the launch.
  task automatic run_sweep(input string nm, input bit m, input bit cont,
                           input int lo_v, input int hi_v, input int st0, input int st1,
                           input int dw, input int stop_at);
    int per0, n, p_len, end_c, t_len, idx, last_upd;
    bit is_upd;
    logic [EW-1:0] e;
    per0  = period(m, lo_v, hi_v, st0);
    p_len = dw + 1;
    n     = cont ? 32'h3fff_ffff : per0 + 1;
    last_upd = 1 + (n - 1) * p_len;
    end_c = cont ? stop_at + 1 : last_upd;
    if (stop_at > 0 && stop_at + 1 < end_c) end_c = stop_at + 1;
    t_len = end_c + 3;
    start = 1'b1; stop = 1'b0; mode = m; continuous = cont;
    lo = WIDTH'(lo_v); hi = WIDTH'(hi_v);
    step = {WIDTH'(st1), WIDTH'(st0)};
    dwell = DWELL_W'(dw);
    @(negedge clk);
    for (int c = 1; c <= t_len; c++) begin
      idx    = (c - 1) / p_len;
      is_upd = ((c - 1) % p_len == 0) && (idx < n) && (stop_at == 0 || c <= stop_at);
      if (is_upd) begin
        e[WIDTH-1:0]       = out_map(sample_at(m, lo_v, hi_v, st0, idx));
        e[DW-1:WIDTH]      = out_map(sample_at(m, lo_v, hi_v, st1, idx));
        e[DW]              = (idx > 0) && (idx % per0 == 0);
        exp_q.push_back(e);
      end
      check({nm, ".valid"}, 64'(data_valid), 64'(is_upd));
      check({nm, ".busy"}, 64'(busy), 64'(c < end_c));
      check({nm, ".err"}, 64'(err), 64'd0);
      if (data_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({nm, ".data"}, 64'(dac_data), 64'(e[DW-1:0]));
        check({nm, ".done"}, 64'(done), 64'(e[DW]));
        held = e[DW-1:0];
      end else begin
        check({nm, ".hold"}, 64'(dac_data), 64'(held));
        check({nm, ".nodone"}, 64'(done), 64'd0);
      end
      // Inputs for the edge ending this cycle: ignored while busy.
      scramble_inputs();
      start = (c < end_c) && ($urandom_range(0, 3) == 0);
      stop  = 1'b0;
      if (c == stop_at) begin
        start = 1'b1;
        stop  = 1'b1;
      end
      @(negedge clk);
    end
    check({nm, ".drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    idle_inputs();
  endtask

  task automatic err_case(input string nm, input int lo_v, input int hi_v);
    start = 1'b1; stop = 1'b0;
    lo = WIDTH'(lo_v); hi = WIDTH'(hi_v); step = DW'($urandom); dwell = '0;
    @(negedge clk);
    start = 1'b0;
    check({nm, ".err"}, 64'(err), 64'd1);
    check({nm, ".busy"}, 64'(busy), 64'd0);
    check({nm, ".valid"}, 64'(data_valid), 64'd0);
    @(negedge clk);
    check({nm, ".err_off"}, 64'(err), 64'd0);
    check({nm, ".busy_off"}, 64'(busy), 64'd0);
    check({nm, ".hold"}, 64'(dac_data), 64'(held));
  endtask

  task automatic start_stop_idle();
    start = 1'b1; stop = 1'b1; lo = WIDTH'(-3); hi = WIDTH'(9); step = {16'd1, 16'd2};
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("ss_idle.busy", 64'(busy), 64'd0);
    check("ss_idle.valid", 64'(data_valid), 64'd0);
    check("ss_idle.err", 64'(err), 64'd0);
    @(negedge clk);
    check("ss_idle.busy2", 64'(busy), 64'd0);
  endtask

  task automatic reset_mid_run();
    start = 1'b1; mode = 1'b0; continuous = 1'b1;
    lo = WIDTH'(-50); hi = WIDTH'(50); step = {16'd7, 16'd3}; dwell = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(5, 20)) @(negedge clk);
    check("rst_mid.busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.data", 64'(dac_data), 64'(reset_word()));
    check("rst_mid.valid", 64'(data_valid), 64'd0);
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    held = reset_word();
    repeat (3) begin
      @(negedge clk);
      check("rst_mid.idle_busy", 64'(busy), 64'd0);
      check("rst_mid.idle_done", 64'(done), 64'd0);
      check("rst_mid.idle_data", 64'(dac_data), 64'(held));
    end
    idle_inputs();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence / final report ----------------
  initial begin
    int lo_r, hi_r, s0, s1, dw_r, sa;
    bit m_r, c_r;
    idle_inputs();
    reset = 1'b1;
    #1;
    check("reset.data", 64'(dac_data), 64'(reset_word()));
    check("reset.valid", 64'(data_valid), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    held = reset_word();
    @(negedge clk);

    run_sweep("saw_single", 1'b0, 1'b0, -4, 4, 3, 1, 0, 0);
    run_sweep("tri_dwell", 1'b1, 1'b0, 0, 5, 2, 0, 2, 0);
    run_sweep("boundary", 1'b0, 1'b0, 32752, 32767, 65535, 65535, 0, 0);
    run_sweep("full_range", 1'b1, 1'b0, -32768, 32767, 65535, 32768, 1, 0);
    err_case("err_equal", 5, 5);
    err_case("err_inverted", 100, -100);
    start_stop_idle();
    run_sweep("saw_cont_stop", 1'b0, 1'b1, -10, 20, 4, 3, 1, 23);
    run_sweep("tri_cont_stop", 1'b1, 1'b1, -6, 6, 5, 2, 0, 40);
    run_sweep("stop_in_load", 1'b1, 1'b0, 0, 30, 3, 3, 0, 1);

    for (int i = 0; i < 12; i++) begin
      m_r  = 1'($urandom);
      c_r  = 1'($urandom);
      lo_r = int'($urandom_range(0, 200)) - 100;
      hi_r = lo_r + int'($urandom_range(1, 40));
      s0   = int'($urandom_range(1, 12));
      s1   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      dw_r = int'($urandom_range(0, 3));
      if (c_r) sa = int'($urandom_range(1, 60));
      else     sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_sweep($sformatf("rand%0d", i), m_r, c_r, lo_r, hi_r, s0, s1, dw_r, sa);
    end

    reset_mid_run();
    run_sweep("after_reset", 1'b0, 1'b0, -4, 4, 3, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
